// File: rtl/updown_mon_pkg.sv
// Shared types and constants for the up/down counter monitor.
package updown_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } mon_state_e;

  localparam int unsigned LOCK_CNT_MAX = 15;
  localparam int unsigned MATCH_W      = $clog2(LOCK_CNT_MAX + 1);

endpackage

// File: rtl/updown_predict.sv
// Combinational next-count predictor for the up/down counter monitor.
module updown_predict #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] prev_cnt,
  input  logic             m,
  input  logic             ta,
  output logic [WIDTH-1:0] pred,
  output logic             wrap_cond
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  always_comb begin
    pred      = prev_cnt;
    wrap_cond = 1'b0;
    if (ta) begin
      if (m) begin
        pred      = prev_cnt + CNT_ONE;
        wrap_cond = (prev_cnt == CNT_MAX);
      end else begin
        pred      = prev_cnt - CNT_ONE;
        wrap_cond = (prev_cnt == '0);
      end
    end
  end

endmodule

// File: rtl/updown_count_monitor.sv
// Passive checker for the up/down counter: predicts each sample from the previous one,
// tracks lock, counts mismatches and flags wrap-around.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | first edge after reset: capture sample only, no compare
// ST_ACQ    | counting consecutive matches toward LOCK_CNT, errors ignored
// ST_LOCKED | tracking; a mismatch pulses, counts an error and drops to ACQ
module updown_count_monitor
  import updown_mon_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m,
  input  logic             ta,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             mismatch,
  output logic             wrap,
  output logic [WIDTH-1:0] expected,
  output logic [ERR_W-1:0] err_count
);

  // Out-of-range LOCK_CNT is clamped into 1..LOCK_CNT_MAX so the match counter cannot overrun.
  localparam int unsigned LOCK_CLAMP = (LOCK_CNT < 1) ? 1 :
                                       (LOCK_CNT > LOCK_CNT_MAX) ? LOCK_CNT_MAX : LOCK_CNT;
  localparam logic [MATCH_W-1:0] LOCK_TGT  = MATCH_W'(LOCK_CLAMP);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
  localparam logic [ERR_W-1:0]   ERR_ONE   = ERR_W'(1);

  mon_state_e       state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WIDTH-1:0] prev_cnt_q;
  logic             prev_m_q, prev_ta_q;
  logic [WIDTH-1:0] expected_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic             locked_q, locked_d;
  logic             mismatch_q, mismatch_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] pred;
  logic             wrap_cond;
  logic             hit;

  updown_predict #(
    .WIDTH (WIDTH)
  ) u_predict (
    .prev_cnt  (prev_cnt_q),
    .m         (prev_m_q),
    .ta        (prev_ta_q),
    .pred      (pred),
    .wrap_cond (wrap_cond)
  );

  assign hit = (count_in == pred);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_ACQ;
        match_d = '0;
      end
      ST_ACQ: begin
        if (hit) begin
          match_d = match_q + MATCH_ONE;
          if (match_d == LOCK_TGT) begin
            state_d = ST_LOCKED;
          end
        end else begin
          match_d = '0;
        end
      end
      ST_LOCKED: begin
        if (!hit) begin
          state_d = ST_ACQ;
          match_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        match_d = '0;
      end
    endcase
  end

  always_comb begin
    locked_d   = (state_d == ST_LOCKED);
    mismatch_d = (state_q == ST_LOCKED) && !hit;
    wrap_d     = (state_q == ST_LOCKED) && hit && wrap_cond;
    err_d      = err_q;
    // Clear takes priority over a simultaneous increment.
    if (clr_err) begin
      err_d = '0;
    end else if (mismatch_d && (err_q != '1)) begin
      err_d = err_q + ERR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_q    <= '0;
      prev_cnt_q <= '0;
      prev_m_q   <= 1'b0;
      prev_ta_q  <= 1'b0;
      expected_q <= '0;
      err_q      <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      match_q    <= match_d;
      prev_cnt_q <= count_in;
      prev_m_q   <= m;
      prev_ta_q  <= ta;
      expected_q <= pred;
      err_q      <= err_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      wrap_q     <= wrap_d;
    end
  end

  assign locked    = locked_q;
  assign mismatch  = mismatch_q;
  assign wrap      = wrap_q;
  assign expected  = expected_q;
  assign err_count = err_q;

endmodule
